// File: rtl/led_sequencer.sv
// Button-driven LED state sequencer: debounced up/down steps plus optional
// periodic auto-advance over NUM_STATES states, with wrap or saturate at the ends.

module led_seq_deb #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic step
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          s1_q, s2_q;
  logic          deb_q, deb_d, deb_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Accept a new level only after it has differed from deb for DEB_CYCLES samples.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (s2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
      deb_d = ~deb_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= btn_raw;
      s2_q      <= s1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
    end
  end

  assign step = deb_q & ~deb_dly_q;
endmodule

module led_sequencer #(
  parameter  int NUM_STATES  = 4,
  parameter  int LED_W       = 3,
  parameter  int DEB_CYCLES  = 4,
  parameter  int AUTO_PERIOD = 50_000_000,
  parameter  int WRAP        = 1,
  localparam int STATE_W     = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_dn,
  input  logic               auto_en,
  output logic [LED_W-1:0]   ledout,
  output logic [STATE_W-1:0] state,
  output logic               wrap_pulse
);
  localparam int                 AW   = $clog2(AUTO_PERIOD);
  localparam logic [STATE_W-1:0] LAST = STATE_W'(NUM_STATES - 1);

  logic [1:0]         btn_raw;
  logic [1:0]         step;    // [0] up, [1] down
  logic [AW-1:0]      tmr_q, tmr_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               wrap_q, wrap_d;
  logic               tick, man_one, go_up, go_dn;

  assign btn_raw = {btn_dn, btn_up};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    led_seq_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_raw[i]),
      .step    (step[i])
    );
  end

  // A lone manual pulse wins and restarts the auto period; a coincident tick is dropped.
  always_comb begin
    tick    = auto_en && (tmr_q == AW'(AUTO_PERIOD - 1));
    man_one = step[0] ^ step[1];
    go_up   = man_one ? step[0] : (~step[0] & tick);
    go_dn   = man_one & step[1];
    tmr_d   = (!auto_en || man_one || tick) ? '0 : tmr_q + AW'(1);

    state_d = state_q;
    wrap_d  = 1'b0;
    if (go_up) begin
      if (state_q == LAST) begin
        if (WRAP != 0) begin
          state_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        state_d = state_q + STATE_W'(1);
      end
    end else if (go_dn) begin
      if (state_q == '0) begin
        if (WRAP != 0) begin
          state_d = LAST;
          wrap_d  = 1'b1;
        end
      end else begin
        state_d = state_q - STATE_W'(1);
      end
    end
    led_d = LED_W'(state_d) + LED_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q   <= '0;
      state_q <= '0;
      led_q   <= LED_W'(1);
      wrap_q  <= 1'b0;
    end else begin
      tmr_q   <= tmr_d;
      state_q <= state_d;
      led_q   <= led_d;
      wrap_q  <= wrap_d;
    end
  end

  assign ledout     = led_q;
  assign state      = state_q;
  assign wrap_pulse = wrap_q;
endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: three configurations share stimulus and are checked
// against a cycle-level behavioural model plus directed expectations.

module tb_led_sequencer;
  localparam int DEB = 4;
  localparam int P   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 1'b0;
  logic btn_dn = 1'b0;
  logic auto_en = 1'b0;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int ns [3] = '{4, 4, 5};
  bit wr [3] = '{1'b1, 1'b0, 1'b1};

  logic [2:0] led_a, led_b, led_c;
  logic [1:0] st_a, st_b;
  logic [2:0] st_c;
  logic       wp_a, wp_b, wp_c;

  led_sequencer #(.NUM_STATES(4), .LED_W(3), .DEB_CYCLES(DEB), .AUTO_PERIOD(P), .WRAP(1)) dut_a (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .auto_en(auto_en),
    .ledout(led_a), .state(st_a), .wrap_pulse(wp_a));
  led_sequencer #(.NUM_STATES(4), .LED_W(3), .DEB_CYCLES(DEB), .AUTO_PERIOD(P), .WRAP(0)) dut_b (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .auto_en(auto_en),
    .ledout(led_b), .state(st_b), .wrap_pulse(wp_b));
  led_sequencer #(.NUM_STATES(5), .LED_W(3), .DEB_CYCLES(DEB), .AUTO_PERIOD(P), .WRAP(1)) dut_c (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .auto_en(auto_en),
    .ledout(led_c), .state(st_c), .wrap_pulse(wp_c));

  logic [2:0] led_o [3];
  logic [2:0] st_o  [3];
  logic       wp_o  [3];
  assign led_o[0] = led_a;          assign led_o[1] = led_b;          assign led_o[2] = led_c;
  assign st_o[0]  = {1'b0, st_a};   assign st_o[1]  = {1'b0, st_b};   assign st_o[2]  = st_c;
  assign wp_o[0]  = wp_a;           assign wp_o[1]  = wp_b;           assign wp_o[2]  = wp_c;

  // Reference model: a press is accepted once the synchronised level has
  // disagreed with the accepted level for the last DEB samples.
  logic [2:0] m_st  [3];
  logic [2:0] m_led [3];
  logic       m_wp  [3];
  bit ms1 [2];
  bit ms2 [2];
  bit mdeb [2];
  bit mdebd [2];
  bit win [2][DEB];
  int mtmr;

  task automatic cycle();
    bit raw [2];
    bit pu, pd, tick, one, diff;
    int dir, n;
    raw[0] = btn_up;
    raw[1] = btn_dn;
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        m_st[c] = 3'd0; m_led[c] = 3'd1; m_wp[c] = 1'b0;
      end
      for (int b = 0; b < 2; b++) begin
        ms1[b] = 0; ms2[b] = 0; mdeb[b] = 0; mdebd[b] = 0;
        for (int k = 0; k < DEB; k++) win[b][k] = 0;
      end
      mtmr = 0;
    end else begin
      pu = mdeb[0] & ~mdebd[0];
      pd = mdeb[1] & ~mdebd[1];
      for (int b = 0; b < 2; b++) begin
        for (int k = DEB - 1; k > 0; k--) win[b][k] = win[b][k-1];
        win[b][0] = ms2[b];
        diff = 1;
        for (int k = 0; k < DEB; k++) if (win[b][k] == mdeb[b]) diff = 0;
        mdebd[b] = mdeb[b];
        if (diff) mdeb[b] = ~mdeb[b];
        ms2[b] = ms1[b];
        ms1[b] = raw[b];
      end
      tick = auto_en && (mtmr == P - 1);
      one  = pu ^ pd;
      if (one) dir = pu ? 1 : -1;
      else     dir = (!pu && tick) ? 1 : 0;
      mtmr = (!auto_en || one || tick) ? 0 : mtmr + 1;
      for (int c = 0; c < 3; c++) begin
        n = int'(m_st[c]) + dir;
        m_wp[c] = 1'b0;
        if (n < 0) begin
          if (wr[c]) begin n = ns[c] - 1; m_wp[c] = 1'b1; end
          else n = 0;
        end else if (n >= ns[c]) begin
          if (wr[c]) begin n = 0; m_wp[c] = 1'b1; end
          else n = ns[c] - 1;
        end
        m_st[c]  = 3'(n);
        m_led[c] = 3'(n + 1);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1; btn_up = 1'b0; btn_dn = 1'b0; auto_en = 1'b0;
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] exp_st;
    logic [2:0] exp_led;
    rst = 1'b1; btn_up = 1'b1; btn_dn = 1'b0; auto_en = 1'b0;
    repeat (3) begin
      cycle();
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (led_o[c] !== 3'b001 || st_o[c] !== 3'd0 || wp_o[c] !== 1'b0) begin
          errors++;
          $display("FAIL reset_hold cfg%0d: led/state/wrap got %b/%0d/%b want 001/0/0",
                   c, led_o[c], st_o[c], wp_o[c]);
        end
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      cycle();
      exp_st  = (e >= 7) ? 2'd1 : 2'd0;
      exp_led = {1'b0, exp_st} + 3'd1;
      checks++;
      if (st_a !== exp_st || led_a !== exp_led) begin
        errors++;
        $display("FAIL reset_release edge%0d: state/led got %0d/%b want %0d/%b",
                 e, st_a, led_a, exp_st, exp_led);
      end
    end
    btn_up = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [2:0] exp_led [5] = '{3'b010, 3'b011, 3'b100, 3'b001, 3'b010};
    int wcnt;
    apply_reset(2);
    for (int p = 0; p < 5; p++) begin
      wcnt = 0;
      for (int k = 0; k < 20; k++) begin
        btn_up = (k < 10);
        cycle();
        if (wp_a === 1'b1) wcnt++;
        for (int c = 0; c < 3; c++) begin
          checks++;
          if ({led_o[c], st_o[c], wp_o[c]} !== {m_led[c], m_st[c], m_wp[c]}) begin
            errors++;
            $display("FAIL model_up_wrap cfg%0d @%0t: led/state/wrap got %b/%0d/%b want %b/%0d/%b",
                     c, $time, led_o[c], st_o[c], wp_o[c], m_led[c], m_st[c], m_wp[c]);
          end
        end
      end
      checks++;
      if (led_a !== exp_led[p]) begin
        errors++;
        $display("FAIL up_wrap_led press%0d: got %b want %b", p, led_a, exp_led[p]);
      end
      checks++;
      if (wcnt != ((p == 3) ? 1 : 0)) begin
        errors++;
        $display("FAIL up_wrap_pulse press%0d: got %0d pulses want %0d", p, wcnt, (p == 3) ? 1 : 0);
      end
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_b [7] = '{2'd1, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
    int wcnt = 0;
    apply_reset(2);
    for (int p = 0; p < 7; p++) begin
      for (int k = 0; k < 20; k++) begin
        btn_up = (p < 2) && (k < 10);
        btn_dn = (p >= 2) && (k < 10);
        cycle();
        if (wp_b === 1'b1) wcnt++;
        for (int c = 0; c < 3; c++) begin
          checks++;
          if ({led_o[c], st_o[c], wp_o[c]} !== {m_led[c], m_st[c], m_wp[c]}) begin
            errors++;
            $display("FAIL model_saturate cfg%0d @%0t: led/state/wrap got %b/%0d/%b want %b/%0d/%b",
                     c, $time, led_o[c], st_o[c], wp_o[c], m_led[c], m_st[c], m_wp[c]);
          end
        end
      end
      checks++;
      if (st_b !== exp_b[p]) begin
        errors++;
        $display("FAIL saturate_state press%0d: got %0d want %0d", p, st_b, exp_b[p]);
      end
    end
    checks++;
    if (wcnt != 0) begin
      errors++;
      $display("FAIL saturate_wrap_pulse: got %0d pulses want 0", wcnt);
    end
  endtask

  task automatic test_debounce();
    logic [1:0] exp_st;
    apply_reset(2);
    for (int k = 0; k < 15; k++) begin
      btn_up = (k < 3);
      cycle();
      checks++;
      if (st_a !== 2'd0 || led_a !== 3'b001) begin
        errors++;
        $display("FAIL debounce_glitch cyc%0d: state/led got %0d/%b want 0/001", k, st_a, led_a);
      end
    end
    for (int e = 1; e <= 12; e++) begin
      btn_up = (e <= 4);
      cycle();
      exp_st = (e >= 7) ? 2'd1 : 2'd0;
      checks++;
      if (st_a !== exp_st) begin
        errors++;
        $display("FAIL debounce_press edge%0d: state got %0d want %0d", e, st_a, exp_st);
      end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({led_o[c], st_o[c], wp_o[c]} !== {m_led[c], m_st[c], m_wp[c]}) begin
          errors++;
          $display("FAIL model_debounce cfg%0d @%0t: led/state/wrap got %b/%0d/%b want %b/%0d/%b",
                   c, $time, led_o[c], st_o[c], wp_o[c], m_led[c], m_st[c], m_wp[c]);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic v;
    apply_reset(2);
    for (int k = 0; k < 100; k++) begin
      v = (k < 40) ? ((k % 20) < 10) : 1'($urandom_range(0, 1));
      btn_up = v;
      btn_dn = v;
      cycle();
      checks++;
      if (st_a !== 2'd0 || st_b !== 2'd0 || st_c !== 3'd0) begin
        errors++;
        $display("FAIL simultaneous cyc%0d: states got %0d/%0d/%0d want 0/0/0", k, st_a, st_b, st_c);
      end
    end
    btn_up = 1'b0;
    btn_dn = 1'b0;
  endtask

  task automatic test_priority();
    logic [1:0] exp_st;
    logic       exp_wp;
    apply_reset(2);
    auto_en = 1'b1;
    for (int e = 1; e <= 33; e++) begin
      btn_up = (e >= 2 && e <= 9) || (e >= 17 && e <= 26);
      cycle();
      exp_st = (e < 8) ? 2'd0 : (e < 16) ? 2'd1 : (e < 23) ? 2'd2 : (e < 31) ? 2'd3 : 2'd0;
      exp_wp = (e == 31);
      checks++;
      if (st_a !== exp_st || wp_a !== exp_wp) begin
        errors++;
        $display("FAIL priority edge%0d: state/wrap got %0d/%b want %0d/%b", e, st_a, wp_a, exp_st, exp_wp);
      end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({led_o[c], st_o[c], wp_o[c]} !== {m_led[c], m_st[c], m_wp[c]}) begin
          errors++;
          $display("FAIL model_priority cfg%0d @%0t: led/state/wrap got %b/%0d/%b want %b/%0d/%b",
                   c, $time, led_o[c], st_o[c], wp_o[c], m_led[c], m_st[c], m_wp[c]);
        end
      end
    end
    auto_en = 1'b0;
    btn_up  = 1'b0;
  endtask

  task automatic test_auto();
    logic [2:0] exp_led [5] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b001};
    apply_reset(2);
    auto_en = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      cycle();
      if (e % 8 == 0) begin
        checks++;
        if (led_c !== exp_led[e/8 - 1]) begin
          errors++;
          $display("FAIL auto_led edge%0d: got %b want %b", e, led_c, exp_led[e/8 - 1]);
        end
      end
      checks++;
      if (wp_c !== (e == 40)) begin
        errors++;
        $display("FAIL auto_wrap_pulse edge%0d: got %b want %b", e, wp_c, (e == 40));
      end
    end
    auto_en = 1'b0;
  endtask

  task automatic test_random();
    int ul = 0, dl = 0, rl = 0;
    apply_reset(2);
    for (int k = 0; k < 3000; k++) begin
      if (ul == 0) begin btn_up = 1'($urandom_range(0, 1)); ul = $urandom_range(1, 12); end
      ul--;
      if (dl == 0) begin btn_dn = 1'($urandom_range(0, 1)); dl = $urandom_range(1, 12); end
      dl--;
      if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
      if (rl > 0) rl--;
      else if ($urandom_range(0, 299) == 0) rl = $urandom_range(1, 3);
      rst = (rl > 0);
      cycle();
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({led_o[c], st_o[c], wp_o[c]} !== {m_led[c], m_st[c], m_wp[c]}) begin
          errors++;
          $display("FAIL model_random cfg%0d @%0t: led/state/wrap got %b/%0d/%b want %b/%0d/%b",
                   c, $time, led_o[c], st_o[c], wp_o[c], m_led[c], m_st[c], m_wp[c]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_saturate();
    test_debounce();
    test_simultaneous();
    test_priority();
    test_auto();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
